// File: rtl/peak_tracker.sv
// peak_tracker: sweep peak detector for the ADC path.
// Tracks the largest sample of a sweep (compared on the upper bits only,
// with optional hysteresis), the sweep position where it occurred and the
// number of accepted samples, then reports completion with DONE and
// RESULT_VALID. Every output comes straight from a flop.
module peak_tracker #(
  parameter int DATA_W  = 12,
  parameter int CMP_LSB = 6,
  parameter int POS_W   = 8,
  parameter int HYST    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [POS_W-1:0]  pos,
  input  logic              sweep_end,
  output logic              busy,
  output logic              gt,
  output logic [DATA_W-1:0] max_val,
  output logic [POS_W-1:0]  max_pos,
  output logic [POS_W-1:0]  n_samples,
  output logic              done,
  output logic              result_valid
);

  // Width of the compared (truncated) part of a sample.
  localparam int TW = DATA_W - CMP_LSB;
  // Hysteresis widened by one bit so the threshold sum can never wrap.
  localparam logic [TW:0] HYST_EXT = (TW+1)'(HYST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
    logic [POS_W-1:0] r;
    if (v == {POS_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + POS_W'(1);
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                gt_q, gt_d;
  logic [DATA_W-1:0]   max_val_q, max_val_d;
  logic [POS_W-1:0]    max_pos_q, max_pos_d;
  logic [POS_W-1:0]    n_samples_q, n_samples_d;
  logic                done_q, done_d;
  logic                result_valid_q, result_valid_d;
  logic                first_q, first_d;

  logic [TW:0]         threshold_s;
  logic [TW:0]         sample_cmp_s;
  logic                above_s;

  // Truncated comparison: sample must strictly exceed stored max plus hysteresis.
  always_comb begin
    threshold_s  = {1'b0, max_val_q[DATA_W-1:CMP_LSB]} + HYST_EXT;
    sample_cmp_s = {1'b0, sample[DATA_W-1:CMP_LSB]};
    above_s      = (sample_cmp_s > threshold_s);
  end

  // Next-state and next-output computation for the sweep controller.
  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    gt_d           = 1'b0;
    max_val_d      = max_val_q;
    max_pos_d      = max_pos_q;
    n_samples_d    = n_samples_q;
    done_d         = 1'b0;
    result_valid_d = result_valid_q;
    first_d        = first_q;

    if (start) begin
      // START wins in every state: clear results and (re)begin a sweep,
      // discarding any sample presented on the same edge.
      state_d        = ST_SWEEP;
      busy_d         = 1'b1;
      max_val_d      = {DATA_W{1'b0}};
      max_pos_d      = {POS_W{1'b0}};
      n_samples_d    = {POS_W{1'b0}};
      result_valid_d = 1'b0;
      first_d        = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Samples and sweep ends are ignored until a START arrives.
          state_d = ST_IDLE;
        end
        ST_SWEEP: begin
          if (sample_valid) begin
            n_samples_d = sat_inc(n_samples_q);
            if (first_q || above_s) begin
              // Strict compare means ties keep the earlier position.
              max_val_d = sample;
              max_pos_d = pos;
              gt_d      = 1'b1;
              first_d   = 1'b0;
            end else begin
              max_val_d = max_val_q;
              max_pos_d = max_pos_q;
            end
          end else begin
            n_samples_d = n_samples_q;
          end
          if (sweep_end) begin
            // A sample on the same edge has already been folded in above.
            state_d        = ST_HOLD;
            busy_d         = 1'b0;
            done_d         = 1'b1;
            result_valid_d = 1'b1;
          end else begin
            state_d = ST_SWEEP;
          end
        end
        ST_HOLD: begin
          // Results are frozen until the next START.
          state_d = ST_HOLD;
        end
        default: begin
          state_d        = ST_IDLE;
          busy_d         = 1'b0;
          result_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      gt_q           <= 1'b0;
      max_val_q      <= {DATA_W{1'b0}};
      max_pos_q      <= {POS_W{1'b0}};
      n_samples_q    <= {POS_W{1'b0}};
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      first_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      gt_q           <= gt_d;
      max_val_q      <= max_val_d;
      max_pos_q      <= max_pos_d;
      n_samples_q    <= n_samples_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
      first_q        <= first_d;
    end
  end

  assign busy         = busy_q;
  assign gt           = gt_q;
  assign max_val      = max_val_q;
  assign max_pos      = max_pos_q;
  assign n_samples    = n_samples_q;
  assign done         = done_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_peak_tracker.sv
// tb_peak_tracker: drives three peak_tracker instances (default, HYST=1,
// POS_W=4) with one shared stimulus stream. Expected outputs from a small
// behavioural model are queued when each cycle is driven and compared once
// the DUTs have clocked; directed constant checks cover the named scenarios.
module tb_peak_tracker;

  localparam int L = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, sv, se;
  logic [11:0] smp;
  logic [7:0]  pos;

  logic        busy0, gt0, done0, rv0;
  logic [11:0] mv0;
  logic [7:0]  mp0, n0;
  logic        busy1, gt1, done1, rv1;
  logic [11:0] mv1;
  logic [7:0]  mp1, n1;
  logic        busy2, gt2, done2, rv2;
  logic [11:0] mv2;
  logic [3:0]  mp2, n2;

  peak_tracker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sv),
    .sample(smp), .pos(pos), .sweep_end(se),
    .busy(busy0), .gt(gt0), .max_val(mv0), .max_pos(mp0),
    .n_samples(n0), .done(done0), .result_valid(rv0)
  );

  peak_tracker #(.HYST(1)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sv),
    .sample(smp), .pos(pos), .sweep_end(se),
    .busy(busy1), .gt(gt1), .max_val(mv1), .max_pos(mp1),
    .n_samples(n1), .done(done1), .result_valid(rv1)
  );

  peak_tracker #(.POS_W(4)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sv),
    .sample(smp), .pos(pos[3:0]), .sweep_end(se),
    .busy(busy2), .gt(gt2), .max_val(mv2), .max_pos(mp2),
    .n_samples(n2), .done(done2), .result_valid(rv2)
  );

  typedef struct {
    int st;      // 0 idle, 1 sweep, 2 hold
    int mv;
    int mp;
    int n;
    bit gt;
    bit dn;
    bit rv;
    bit first;
  } mdl_t;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb_q[$];
  mdl_t m0, m1, m2;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge.
  function automatic mdl_t mdl_next(input mdl_t m, input bit r, input bit st, input bit v,
                                    input logic [11:0] s, input int p, input bit e,
                                    input int hyst, input int pmax);
    mdl_t x;
    x    = m;
    x.gt = 1'b0;
    x.dn = 1'b0;
    if (!r) begin
      x = '{st: 0, mv: 0, mp: 0, n: 0, gt: 1'b0, dn: 1'b0, rv: 1'b0, first: 1'b0};
    end else if (st) begin
      x.st = 1; x.mv = 0; x.mp = 0; x.n = 0; x.rv = 1'b0; x.first = 1'b1;
    end else if (m.st == 1) begin
      if (v) begin
        if (m.n < pmax) x.n = m.n + 1;
        if (m.first || ((int'(s) >> L) > ((m.mv >> L) + hyst))) begin
          x.mv = int'(s); x.mp = p; x.gt = 1'b1; x.first = 1'b0;
        end
      end
      if (e) begin
        x.st = 2; x.dn = 1'b1; x.rv = 1'b1;
      end
    end
    return x;
  endfunction

  function automatic logic [31:0] pack_m(input mdl_t m);
    return {(m.st == 1), m.gt, m.dn, m.rv, 12'(m.mv), 8'(m.mp), 8'(m.n)};
  endfunction

  function automatic logic [31:0] act0();
    return {busy0, gt0, done0, rv0, mv0, mp0, n0};
  endfunction

  function automatic logic [31:0] act1();
    return {busy1, gt1, done1, rv1, mv1, mp1, n1};
  endfunction

  function automatic logic [31:0] act2();
    return {busy2, gt2, done2, rv2, mv2, 4'h0, mp2, 4'h0, n2};
  endfunction

  // Drive one cycle, queue the model prediction, then compare after the edge.
  task automatic step(input bit r, input bit st, input bit v, input logic [11:0] s,
                      input logic [7:0] p, input bit e);
    exp_t x;
    rst_n = r; start = st; sv = v; smp = s; pos = p; se = e;
    m0 = mdl_next(m0, r, st, v, s, int'(p), e, 0, 255);
    m1 = mdl_next(m1, r, st, v, s, int'(p), e, 1, 255);
    m2 = mdl_next(m2, r, st, v, s, int'(p) & 15, e, 0, 15);
    x.e0 = pack_m(m0);
    x.e1 = pack_m(m1);
    x.e2 = pack_m(m2);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq("cyc_dut0", act0(), x.e0);
    check_eq("cyc_duth", act1(), x.e1);
    check_eq("cyc_duts", act2(), x.e2);
  endtask

  logic [11:0] bs [5];
  logic [4:0]  gtp;

  initial begin
    m0 = '{st: 0, mv: 0, mp: 0, n: 0, gt: 1'b0, dn: 1'b0, rv: 1'b0, first: 1'b0};
    m1 = m0;
    m2 = m0;
    rst_n = 1'b0; start = 1'b0; sv = 1'b0; se = 1'b0; smp = 12'h000; pos = 8'h00;
    bs = '{12'h100, 12'h400, 12'h7C0, 12'h7FF, 12'h200};

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 12'h000, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 8'd0, 1'b0);
    check_eq("reset_d0", act0(), 32'h0000_0000);

    // Reset in the middle of a sweep, then a sample that must be ignored.
    step(1'b1, 1'b1, 1'b0, 12'h000, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 12'h800, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 12'h100, 8'd1, 1'b0);
    check_eq("pre_rst_max", 32'(mv0), 32'h800);
    step(1'b0, 1'b0, 1'b1, 12'h900, 8'd2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 12'h900, 8'd3, 1'b0);
    check_eq("midrst_d0", act0(), 32'h0000_0000);
    check_eq("midrst_ds", act2(), 32'h0000_0000);
    step(1'b1, 1'b0, 1'b1, 12'hFFF, 8'd4, 1'b0);
    check_eq("idle_ignore", act0(), 32'h0000_0000);

    // Basic sweep.
    step(1'b1, 1'b1, 1'b0, 12'h000, 8'd0, 1'b0);
    check_eq("start_busy", 32'(busy0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, bs[i], 8'(i), (i == 4));
      gtp[i] = gt0;
    end
    check_eq("basic_gt", 32'(gtp), 32'h07);
    check_eq("basic_max", 32'(mv0), 32'h7C0);
    check_eq("basic_pos", 32'(mp0), 32'd2);
    check_eq("basic_n", 32'(n0), 32'd5);
    check_eq("basic_done", {30'd0, done0, rv0}, 32'h3);
    step(1'b1, 1'b0, 1'b0, 12'h000, 8'd0, 1'b0);
    check_eq("basic_after", {29'd0, busy0, done0, rv0}, 32'h1);

    // Hysteresis sweep.
    step(1'b1, 1'b1, 1'b0, 12'h000, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 12'h400, 8'd0, 1'b0);
    gtp[0] = gt1;
    step(1'b1, 1'b0, 1'b1, 12'h440, 8'd1, 1'b0);
    gtp[1] = gt1;
    step(1'b1, 1'b0, 1'b1, 12'h480, 8'd2, 1'b1);
    gtp[2] = gt1;
    check_eq("hyst_gt", {29'd0, gtp[2:0]}, 32'h5);
    check_eq("hyst_max", 32'(mv1), 32'h480);
    check_eq("hyst_pos", 32'(mp1), 32'd2);

    // Sweep with no samples.
    step(1'b1, 1'b1, 1'b0, 12'h000, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 12'h000, 8'd0, 1'b1);
    check_eq("empty_d0", act0(), 32'h3000_0000);

    // Full-scale tie keeps the first position.
    step(1'b1, 1'b1, 1'b0, 12'h000, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 12'hFFF, 8'd5, 1'b0);
    step(1'b1, 1'b0, 1'b1, 12'hFFF, 8'd6, 1'b1);
    check_eq("fs_gt", 32'(gt0), 32'd0);
    check_eq("fs_pos", 32'(mp0), 32'd5);
    check_eq("fs_pos_h", 32'(mp1), 32'd5);
    check_eq("fs_max", 32'(mv0), 32'hFFF);

    // Abort mid-sweep.
    step(1'b1, 1'b1, 1'b0, 12'h000, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 12'h800, 8'd1, 1'b0);
    check_eq("abort_pre", 32'(mv0), 32'h800);
    step(1'b1, 1'b1, 1'b1, 12'h900, 8'd2, 1'b0);
    check_eq("abort_clr", act0(), 32'h8000_0000);
    step(1'b1, 1'b0, 1'b1, 12'h040, 8'd3, 1'b0);
    check_eq("abort_first", act0(), {4'b1100, 12'h040, 8'd3, 8'd1});
    step(1'b1, 1'b0, 1'b0, 12'h000, 8'd0, 1'b1);

    // Counter saturation on the narrow instance.
    step(1'b1, 1'b1, 1'b0, 12'h000, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1, 12'(i * 100), 8'(i), (i == 19));
    end
    check_eq("sat_n_s", 32'(n2), 32'd15);
    check_eq("sat_n_0", 32'(n0), 32'd20);
    check_eq("sat_pos_s", 32'(mp2), 32'd3);

    // HOLD ignores further samples and sweep ends.
    step(1'b1, 1'b0, 1'b1, 12'hFFF, 8'd30, 1'b1);
    step(1'b1, 1'b0, 1'b1, 12'hFFF, 8'd31, 1'b1);
    check_eq("hold_d0", act0(), {4'b0001, 12'h76C, 8'd19, 8'd20});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/peak_tracker.md
# peak_tracker

Parametrised sweep peak detector for the tracker's ADC path. Over one sweep it compares each incoming ADC sample against the stored maximum, ignoring a configurable number of LSBs and applying optional hysteresis. It records the maximum value, the sweep position where that maximum occurred, and the number of accepted samples, then signals completion with a start/done handshake to the sweep controller.

## Interface
- DATA_W, 12, ADC sample width
- CMP_LSB, 6, number of low bits ignored in comparison (0 ≤ CMP_LSB < DATA_W)
- POS_W, 8, width of sweep position and of sample counter
- HYST, 0, hysteresis in truncated-LSB units; new sample must exceed stored max by more than HYST
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- START  in  1  one-cycle pulse; clears result and begins a sweep
- SAMPLE_VALID  in  1  SAMPLE/POS valid this cycle
- SAMPLE  in  DATA_W  ADC value
- POS  in  POS_W  current sweep position (servo step index)
- SWEEP_END  in  1  last sample of sweep; may coincide with SAMPLE_VALID
- BUSY  out  1  high in SWEEP state
- GT  out  1  one-cycle pulse: previous accepted sample became new max
- MAX_VAL  out  DATA_W  stored max sample (full width, not truncated)
- MAX_POS  out  POS_W  POS captured with MAX_VAL
- N_SAMPLES  out  POS_W  accepted samples this sweep, saturating at all-ones
- DONE  out  1  one-cycle pulse on sweep completion
- RESULT_VALID  out  1  high from DONE until next START

## Operation
- States: IDLE, SWEEP, HOLD. Reset → IDLE.
- IDLE: SAMPLE_VALID and SWEEP_END ignored. START → SWEEP.
- SWEEP: each cycle with SAMPLE_VALID=1 is an accepted sample, and N_SAMPLES increments, saturating.
  - First accepted sample of a sweep is always captured (MAX_VAL, MAX_POS load; GT pulses), regardless of value.
  - Later samples are captured iff SAMPLE[DATA_W-1:CMP_LSB] > MAX_VAL[DATA_W-1:CMP_LSB] + HYST.
  - The sum is computed at DATA_W-CMP_LSB+1 bits, so there is no wrap. If the sum exceeds the truncated full-scale, no capture occurs.
  - Ties and values within hysteresis keep the earlier MAX_POS. The first position wins.
  - SWEEP_END=1 → HOLD. If SAMPLE_VALID is also high, that sample is processed normally on the same edge.
  - START in SWEEP aborts and restarts: result cleared, state stays SWEEP, and the sample on that edge is discarded.
- HOLD: outputs frozen, RESULT_VALID=1. SAMPLE_VALID and SWEEP_END ignored. START → SWEEP.
- START clear action: MAX_VAL=0, MAX_POS=0, N_SAMPLES=0, RESULT_VALID=0, first-sample flag set.
- A sweep ending with zero accepted samples still completes. DONE pulses, RESULT_VALID=1, and MAX_VAL, MAX_POS and N_SAMPLES are all 0.
- START takes priority over every other input in every state.

## Timing
- All outputs are registered. Reset values: BUSY=0, GT=0, MAX_VAL=0, MAX_POS=0, N_SAMPLES=0, DONE=0, RESULT_VALID=0.
- RST_N low at any edge, including mid-sweep, forces IDLE and the reset values on that edge.
- START sampled at edge k → BUSY=1 and cleared outputs visible after edge k.
- Sample accepted at edge k → MAX_VAL, MAX_POS, N_SAMPLES and GT are updated after edge k. Latency is 1 cycle. GT is low after edge k+1 unless another capture occurs.
- Back-to-back samples on every cycle are supported, with throughput 1 sample/cycle.
- SWEEP_END at edge k → after edge k: BUSY=0, DONE=1, RESULT_VALID=1. DONE is low after edge k+1.
- DONE and GT may be high in the same cycle when the last sample is a new max.

## Test plan
- **Reset:** RST_N=0 for 2 cycles mid-sweep, with defaults DATA_W=12, CMP_LSB=6, HYST=0 → all outputs 0, state IDLE, and a following SAMPLE_VALID is ignored.
- **Basic sweep:** START, then samples (POS, SAMPLE) = (0,0x100), (1,0x400), (2,0x7C0), (3,0x7FF), (4,0x200) with SWEEP_END on the last sample.
  - GT pulses after samples 0, 1 and 2 only, because 0x7FF truncates equal to 0x7C0.
  - Result: MAX_VAL=0x7C0, MAX_POS=2, N_SAMPLES=5. DONE pulses once and RESULT_VALID=1.
- **Hysteresis:** HYST=1, samples 0x400, 0x440, 0x480 → only 0x400 and 0x480 are captured. MAX_POS indexes 0x480.
- **Edge cases:** a sweep with SWEEP_END and no samples → DONE pulse and all results 0. For full-scale values 0xFFF followed by 0xFFF, MAX_POS stays at the first index and there is no wrap.
- **Abort:** START mid-sweep after MAX_VAL=0x800 → results clear on that edge. The next sample 0x040 is captured as the first sample.
- **Counter saturation and HOLD behaviour:**
  - With POS_W=4, 20 samples → N_SAMPLES=15.
  - In HOLD, further SAMPLE_VALID and SWEEP_END pulses leave outputs unchanged.
